// File: rtl/chunker_pkg.sv
// Shared helpers for the chunker family: chunk count, chunk ordering and
// the elaboration-time configuration checks.
package chunker_pkg;

  // Number of M-bit chunks in an L-bit block.
  function automatic int chunk_count(input int l, input int m);
    return (m > 0) ? (l / m) : 0;
  endfunction

  // A block must split into a whole, non-zero number of chunks.
  function automatic bit chunk_cfg_ok(input int l, input int m);
    return (m > 0) && (l >= m) && ((l % m) == 0);
  endfunction

  // Buffer depths are powers of two, at least one entry.
  function automatic bit is_pow2(input int n);
    return (n >= 1) && ((n & (n - 1)) == 0);
  endfunction

  // Position inside the block (in chunk units) of the k-th chunk sent.
  function automatic int chunk_index(input int k, input int nr, input bit msb_first);
    return msb_first ? (nr - 1 - k) : k;
  endfunction

endpackage

// File: rtl/block_fifo.sv
// Small block buffer: DEPTH entries of WIDTH bits, count-based full/empty.
// Only pointers and count are reset; the storage is left as-is.
module block_fifo
  import chunker_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // With DEPTH=1 the index stays 0, so the second slot is never written.
  localparam int MD = 1 << IW;

  logic [WIDTH-1:0] mem_q [MD];
  logic [IW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  // Next pointers and occupancy; explicit wrap keeps DEPTH=1 at index 0.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == IW'(DEPTH - 1)) ? '0 : wr_q + IW'(1);
    if (do_pop)  rd_d = (rd_q == IW'(DEPTH - 1)) ? '0 : rd_q + IW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count state; reset wins over clear, clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; a write on a clearing edge is harmless since pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/chunker_stream.sv
// Splits buffered L-bit blocks into NR = L/M chunks with valid/ready flow
// control on both sides. Chunk counter lives here; blocks sit in block_fifo.
module chunker_stream
  import chunker_pkg::*;
#(
  parameter int L         = 128,
  parameter int M         = 32,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [L-1:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [M-1:0] q,
  output logic         valid,
  input  logic         out_ready,
  output logic         last
);

  localparam int NR = chunk_count(L, M);
  localparam int KW = (NR > 1) ? $clog2(NR) : 1;

  if (!chunk_cfg_ok(L, M)) begin : g_bad_lm
    $error("chunker_stream: L must be a non-zero multiple of M");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("chunker_stream: DEPTH must be a power of two >= 1");
  end

  logic [L-1:0]           head;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, xfer, k_last;
  logic [KW-1:0]          k_q, k_d;
  logic [NR-1:0][M-1:0]   chunks;
  logic [M-1:0]           cur_chunk;

  // in_ready depends on buffer state only, never on same-cycle handshakes.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign valid    = !fifo_empty;
  assign xfer     = valid && out_ready;
  assign k_last   = (k_q == KW'(NR - 1));
  assign pop      = xfer && k_last;

  block_fifo #(
    .WIDTH (L),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // chunks[k] is the k-th chunk in send order.
  for (genvar g = 0; g < NR; g++) begin : g_chunk
    assign chunks[g] = head[chunk_index(g, NR, MSB_FIRST != 0) * M +: M];
  end

  if (NR == 1) begin : g_one
    assign cur_chunk = chunks[0];
  end else begin : g_many
    assign cur_chunk = chunks[k_q];
  end

  // Advance the chunk counter on each transfer, wrapping after the last one.
  always_comb begin
    k_d = k_q;
    if (xfer) k_d = k_last ? '0 : k_q + KW'(1);
  end

  // Counter register; reset and flush both restart at chunk 0.
  always_ff @(posedge clk) begin
    if (reset)      k_q <= '0;
    else if (flush) k_q <= '0;
    else            k_q <= k_d;
  end

  // Outputs are forced to zero whenever nothing is presented.
  always_comb begin
    q    = '0;
    last = 1'b0;
    if (valid) begin
      q    = cur_chunk;
      last = k_last;
    end
  end

endmodule
